sa_readout: RTL

Parametrised result-drain sequencer for the output-stationary PE array. Once accumulation finishes, it reads out the frozen PE accumulators. It emits one output-channel line per accepted cycle: a PE row in 8x8 mode (mode 0) or a PE column in 1x8 mode (mode 1). It sits between the PE array and the output buffer. It replaces the free-running row counter with start/done control, a programmable line count, non-square array support and a valid/ready output handshake with backpressure.

---
 rtl/sa_readout.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sa_readout.sv
// Result-drain sequencer: streams frozen PE accumulators out one line per accepted
// cycle (PE row in 8x8 mode, PE column in 1x8 mode) over a valid/ready handshake.
module sa_readout #(
  parameter int ROWS  = 32,
  parameter int COLS  = 32,
  parameter int W88   = 24,
  parameter int W18   = 16,
  parameter int PE_W  = 4 * W18,
  parameter int IDX_W = $clog2(((ROWS > COLS) ? ROWS : COLS) + 1),
  parameter int OUT_W = ((COLS * 2 * W88) > (ROWS * 4 * W18)) ? (COLS * 2 * W88)
                                                              : (ROWS * 4 * W18)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mode,
  input  logic [IDX_W-1:0]           n_lines,
  input  logic [ROWS*COLS*PE_W-1:0]  pe_flat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] ROWS_L = IDX_W'(ROWS);
  localparam logic [IDX_W-1:0] COLS_L = IDX_W'(COLS);

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [IDX_W-1:0]   neff_q, neff_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [IDX_W-1:0]   lmax_in;
  logic [IDX_W-1:0]   neff_in;
  logic               sel_mode;
  logic [IDX_W-1:0]   sel_idx;
  logic [OUT_W-1:0]   line;

  // Line count requested at start, clamped to the array dimension being walked.
  always_comb begin
    lmax_in = mode ? COLS_L : ROWS_L;
    neff_in = n_lines;
    if ((n_lines == '0) || (n_lines > lmax_in)) begin
      neff_in = lmax_in;
    end
  end

  // The line mux always prepares the next line to load: line 0 from IDLE, idx+1 in DRAIN.
  always_comb begin
    sel_mode = (state_q == IDLE) ? mode : mode_q;
    sel_idx  = (state_q == IDLE) ? '0 : (out_idx_q + 1'b1);
    line     = '0;
    if (!sel_mode) begin
      if (sel_idx < ROWS_L) begin
        for (int j = 0; j < COLS; j++) begin
          line[j*2*W88 +: 2*W88] = pe_flat[((int'(sel_idx) * COLS) + j) * PE_W +: 2*W88];
        end
      end
    end else begin
      if (sel_idx < COLS_L) begin
        for (int i = 0; i < ROWS; i++) begin
          line[i*2*W18 +: 2*W18] =
            pe_flat[((i * COLS) + int'(sel_idx)) * PE_W +: 2*W18];
          line[ROWS*2*W18 + i*2*W18 +: 2*W18] =
            pe_flat[((i * COLS) + int'(sel_idx)) * PE_W + 2*W18 +: 2*W18];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    neff_d      = neff_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = DRAIN;
          mode_d      = mode;
          neff_d      = neff_in;
          out_valid_d = 1'b1;
          out_data_d  = line;
          out_idx_d   = '0;
          out_last_d  = (neff_in == IDX_W'(1));
          busy_d      = 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (out_idx_q < (neff_q - 1'b1)) begin
            out_data_d = line;
            out_idx_d  = out_idx_q + 1'b1;
            out_last_d = ((out_idx_q + 1'b1) == (neff_q - 1'b1));
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_idx_d   = '0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      neff_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      neff_q      <= neff_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
